// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared widths and the writeback request record.
package rf_arb_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int STARVE_MAX = 4;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO buffering late multi-cycle writeback results.
module wb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  wb_req_t       din,
    output wb_req_t       dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    wb_req_t mem [DEPTH];
    logic [PW-1:0] rp, wp;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between ALU and buffered MDU results,
// with starvation relief and a pending-register scoreboard for decode stalls.
module regfile_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DEPTH = 2,
    parameter int STARVE_MAX = rf_arb_pkg::STARVE_MAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_wr_en,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    input  logic            issue_en,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      Ra,
    input  logic [4:0]      Rb,
    output logic            stall,
    output logic            alu_hold,
    output logic            RegWr,
    output logic [4:0]      Rw,
    output logic [XLEN-1:0] busW
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(DEPTH + 1);
    wb_req_t head;
    logic full, empty, push, gnt_mdu, gnt_alu, inc, src_mdu;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic [31:0] pending;
    assign mdu_ready = count < CW'(DEPTH);
    assign push = mdu_valid && !full && mdu_rd != 5'd0;
    // A hold cycle guarantees the ALU is idle, so the buffer head wins it.
    assign gnt_mdu = !empty && (alu_hold || !alu_wr_en);
    assign gnt_alu = alu_wr_en && !gnt_mdu;
    assign inc = !empty && !gnt_mdu;
    assign stall = (Ra != 5'd0 && pending[Ra]) || (Rb != 5'd0 && pending[Rb]);
    wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(gnt_mdu),
        .din('{rd: mdu_rd, data: mdu_data}),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWr <= 1'b0;
            Rw <= '0;
            busW <= '0;
            src_mdu <= 1'b0;
            alu_hold <= 1'b0;
            starve <= '0;
            pending <= '0;
        end else begin
            RegWr <= gnt_mdu || (gnt_alu && alu_rd != 5'd0);
            src_mdu <= gnt_mdu;
            if (gnt_mdu || gnt_alu) begin
                Rw <= gnt_mdu ? head.rd : alu_rd;
                busW <= gnt_mdu ? head.data : alu_data;
            end
            starve <= inc ? starve + 1'b1 : '0;
            alu_hold <= inc && starve == SW'(STARVE_MAX - 1);
            // Set is applied after clear so a re-issue on the retiring edge stays pending.
            pending <= (pending & ~(32'(RegWr && src_mdu) << Rw))
                     | (32'(issue_en && issue_rd != 5'd0) << issue_rd);
        end
    end
endmodule
